// File: rtl/post_state_serial_nd.sv
// post_state_serial_nd
//   Serial Kalman posterior-state update: x_post = x_prior + K*(z_meas - z_hat)
//   for an NX-state / NZ-measurement filter in signed Q(N-FRAC).FRAC.
//   A single multiplier is shared across all K[i][j]*e[j] products.
//   Inputs are snapshotted when a start is accepted. The result is published
//   atomically with a one-cycle done pulse.
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset (aborts a run, no done)
//   start    run request, sampled only while idle (including the done cycle)
//   x_prior  NX words, element i at [i*N +: N]
//   z_meas   NZ words, element j at [j*N +: N]
//   z_hat    NZ words, element j at [j*N +: N]
//   k_flat   NX*NZ words, K[i][j] at [(i*NZ+j)*N +: N]
//   busy     high from the accepted start up to (not including) the done cycle
//   done     one-cycle pulse, x_post valid
//   x_post   posterior state, same packing as x_prior
//   ovf      innovation or output went out of N-bit range in the last run
module post_state_serial_nd #(
  parameter int N    = 20,
  parameter int FRAC = 10,
  parameter int NX   = 2,
  parameter int NZ   = 2,
  parameter int SAT  = 1,
  parameter int RND  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NX*N-1:0]      x_prior,
  input  logic [NZ*N-1:0]      z_meas,
  input  logic [NZ*N-1:0]      z_hat,
  input  logic [NX*NZ*N-1:0]   k_flat,
  output logic                 busy,
  output logic                 done,
  output logic [NX*N-1:0]      x_post,
  output logic                 ovf
);

  // Accumulator holds x<<<FRAC plus NZ full-width products without overflow.
  localparam int AW  = 2*N + $clog2(NZ) + 1;
  localparam int IW  = (NX > 1) ? $clog2(NX) : 1;
  localparam int JW  = (NZ > 1) ? $clog2(NZ) : 1;
  localparam int KW  = (NX*NZ > 1) ? $clog2(NX*NZ) : 1;
  localparam int HSH = (FRAC > 0) ? FRAC - 1 : 0;

  localparam logic [IW-1:0] I_LAST = IW'(NX - 1);
  localparam logic [JW-1:0] J_LAST = JW'(NZ - 1);

  localparam logic signed [AW-1:0] ONE  = 1;
  localparam logic signed [AW-1:0] MAXV = (ONE <<< (N-1)) - ONE;
  localparam logic signed [AW-1:0] MINV = -(ONE <<< (N-1));
  localparam logic signed [AW-1:0] HALF = (RND != 0 && FRAC > 0) ? (ONE <<< HSH) : '0;

  typedef enum logic [2:0] {S_IDLE, S_INNOV, S_MAC, S_WB, S_DONE} state_t;

  state_t          state;
  logic [IW-1:0]   i_cnt;
  logic [JW-1:0]   j_cnt;
  logic [KW-1:0]   k_idx;

  logic signed [N-1:0]  xp_q   [NX];
  logic signed [N-1:0]  zm_q   [NZ];
  logic signed [N-1:0]  zh_q   [NZ];
  logic signed [N-1:0]  k_q    [NX*NZ];
  logic signed [N-1:0]  e_q    [NZ];
  logic signed [N-1:0]  shadow [NX];
  logic signed [AW-1:0] acc;

  logic signed [AW-1:0]  innov_w;
  logic signed [2*N-1:0] prod_w;
  logic signed [AW-1:0]  rnd_w;
  logic [IW-1:0]         i_nxt;

  function automatic logic out_of_range(input logic signed [AW-1:0] v);
    return (v > MAXV) || (v < MINV);
  endfunction

  // Clamp to N bits when SAT=1, otherwise keep the low N bits (wrap).
  function automatic logic signed [N-1:0] clamp_n(input logic signed [AW-1:0] v);
    if (SAT != 0 && v > MAXV) return MAXV[N-1:0];
    if (SAT != 0 && v < MINV) return MINV[N-1:0];
    return v[N-1:0];
  endfunction

  // Round half up (or floor when RND=0) while dropping FRAC fractional bits.
  function automatic logic signed [AW-1:0] round_shift(input logic signed [AW-1:0] v);
    return (v + HALF) >>> FRAC;
  endfunction

  assign innov_w = AW'(zm_q[j_cnt]) - AW'(zh_q[j_cnt]);
  assign prod_w  = k_q[k_idx] * e_q[j_cnt];
  assign rnd_w   = round_shift(acc);
  assign i_nxt   = i_cnt + 1'b1;

  // Control path: sequencing, handshake, flags and the published result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      i_cnt  <= '0;
      j_cnt  <= '0;
      k_idx  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      ovf    <= 1'b0;
      x_post <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_INNOV;
            busy  <= 1'b1;
            ovf   <= 1'b0;
            i_cnt <= '0;
            j_cnt <= '0;
            k_idx <= '0;
          end
        end
        S_INNOV: begin
          if (out_of_range(innov_w)) ovf <= 1'b1;
          if (j_cnt == J_LAST) begin
            j_cnt <= '0;
            state <= S_MAC;
          end else begin
            j_cnt <= j_cnt + 1'b1;
          end
        end
        S_MAC: begin
          k_idx <= k_idx + 1'b1;
          if (j_cnt == J_LAST) begin
            j_cnt <= '0;
            state <= S_WB;
          end else begin
            j_cnt <= j_cnt + 1'b1;
          end
        end
        S_WB: begin
          if (out_of_range(rnd_w)) ovf <= 1'b1;
          if (i_cnt == I_LAST) begin
            state <= S_DONE;
          end else begin
            i_cnt <= i_nxt;
            state <= S_MAC;
          end
        end
        S_DONE: begin
          for (int g = 0; g < NX; g++) x_post[g*N +: N] <= shadow[g];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Data path: snapshot, innovation, multiply-accumulate and row write-back.
  // The accumulator is preloaded with x_prior_i<<<FRAC on entry to each row.
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: begin
        if (start) begin
          for (int g = 0; g < NX; g++) xp_q[g] <= x_prior[g*N +: N];
          for (int g = 0; g < NZ; g++) begin
            zm_q[g] <= z_meas[g*N +: N];
            zh_q[g] <= z_hat[g*N +: N];
          end
          for (int g = 0; g < NX*NZ; g++) k_q[g] <= k_flat[g*N +: N];
        end
      end
      S_INNOV: begin
        e_q[j_cnt] <= clamp_n(innov_w);
        if (j_cnt == J_LAST) acc <= AW'(xp_q[0]) <<< FRAC;
      end
      S_MAC: acc <= acc + AW'(prod_w);
      S_WB: begin
        shadow[i_cnt] <= clamp_n(rnd_w);
        acc           <= AW'(xp_q[i_nxt]) <<< FRAC;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_post_state_serial_nd.sv
// tb_post_state_serial_nd
//   Self-checking bench for post_state_serial_nd. Three instances:
//   dut (2x2, SAT=1, RND=1), dut_r0 (2x2, SAT=0, RND=0, shares all inputs
//   with dut) and dut_b (NX=4, NZ=3). Expected results come from a
//   plain-arithmetic reference model of the filter update.
module tb_post_state_serial_nd;
  localparam int N    = 20;
  localparam int FRAC = 10;

  logic clk = 1'b0;
  logic rst_n;
  logic start, start_b;

  logic [2*N-1:0]  xp, zm, zh, x_post, x_post_r0;
  logic [4*N-1:0]  kf;
  logic [4*N-1:0]  xp_b, x_post_b;
  logic [3*N-1:0]  zm_b, zh_b;
  logic [12*N-1:0] kf_b;
  logic busy, done, ovf, busy_r0, done_r0, ovf_r0, busy_b, done_b, ovf_b;

  longint mx[4], mzm[3], mzh[3], mk[4][3];
  longint bx[4], bzm[3], bzh[3], bk[4][3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  post_state_serial_nd #(.N(N), .FRAC(FRAC), .NX(2), .NZ(2), .SAT(1), .RND(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_prior(xp), .z_meas(zm), .z_hat(zh),
    .k_flat(kf), .busy(busy), .done(done), .x_post(x_post), .ovf(ovf));

  post_state_serial_nd #(.N(N), .FRAC(FRAC), .NX(2), .NZ(2), .SAT(0), .RND(0)) dut_r0 (
    .clk(clk), .rst_n(rst_n), .start(start), .x_prior(xp), .z_meas(zm), .z_hat(zh),
    .k_flat(kf), .busy(busy_r0), .done(done_r0), .x_post(x_post_r0), .ovf(ovf_r0));

  post_state_serial_nd #(.N(N), .FRAC(FRAC), .NX(4), .NZ(3), .SAT(1), .RND(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .x_prior(xp_b), .z_meas(zm_b), .z_hat(zh_b),
    .k_flat(kf_b), .busy(busy_b), .done(done_b), .x_post(x_post_b), .ovf(ovf_b));

  // ---------------- reference model ----------------
  function automatic longint fitn(input longint v, input int sat, inout bit ov);
    longint lo, hi, span;
    lo = -(longint'(1) << (N-1));
    hi = -lo - 1;
    span = -2 * lo;
    if (v < lo || v > hi) begin
      ov = 1'b1;
      if (sat != 0) return (v < lo) ? lo : hi;
      return ((((v - lo) % span) + span) % span) + lo;
    end
    return v;
  endfunction

  function automatic void model(input int nx, input int nz, input int sat, input int rnd,
                                input longint x[4], input longint z[3], input longint h[3],
                                input longint k[4][3], output longint xo[4], output bit ov);
    longint e[3];
    longint acc;
    ov = 1'b0;
    for (int i = 0; i < 4; i++) xo[i] = 0;
    for (int j = 0; j < 3; j++) e[j] = 0;
    for (int j = 0; j < nz; j++) e[j] = fitn(z[j] - h[j], sat, ov);
    for (int i = 0; i < nx; i++) begin
      acc = x[i] * (longint'(1) << FRAC);
      for (int j = 0; j < nz; j++) acc += k[i][j] * e[j];
      if (rnd != 0) acc += longint'(1) << (FRAC - 1);
      xo[i] = fitn(acc >>> FRAC, sat, ov);
    end
  endfunction

  function automatic longint rs(input int bits);
    return longint'($urandom_range(0, (1 << bits) - 1)) - (longint'(1) << (bits - 1));
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic apply_main();
    for (int i = 0; i < 2; i++) begin
      xp[i*N +: N] = mx[i][N-1:0];
      zm[i*N +: N] = mzm[i][N-1:0];
      zh[i*N +: N] = mzh[i][N-1:0];
      for (int j = 0; j < 2; j++) kf[(i*2+j)*N +: N] = mk[i][j][N-1:0];
    end
  endtask

  task automatic apply_big();
    for (int i = 0; i < 4; i++) xp_b[i*N +: N] = bx[i][N-1:0];
    for (int j = 0; j < 3; j++) begin
      zm_b[j*N +: N] = bzm[j][N-1:0];
      zh_b[j*N +: N] = bzh[j][N-1:0];
    end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 3; j++) kf_b[(i*3+j)*N +: N] = bk[i][j][N-1:0];
  endtask

  task automatic set_main(input longint x0, x1, z0, z1, h0, h1, k00, k01, k10, k11);
    mx[0] = x0;  mx[1] = x1;  mzm[0] = z0;  mzm[1] = z1;  mzh[0] = h0;  mzh[1] = h1;
    mk[0][0] = k00; mk[0][1] = k01; mk[1][0] = k10; mk[1][1] = k11;
  endtask

  task automatic rand_main();
    int w;
    w = (($urandom % 3) == 0) ? 20 : 12;
    for (int i = 0; i < 2; i++) begin
      mx[i] = rs(w);  mzm[i] = rs(w);  mzh[i] = rs(w);
      for (int j = 0; j < 2; j++) mk[i][j] = rs(12);
    end
  endtask

  // One run on dut/dut_r0. pulse_at: cycle index to pulse start mid-run
  // (-1 none); change_at: cycle index to scramble the inputs (-1 none).
  task automatic run_main(input string tag, input int pulse_at, input int change_at);
    longint ex[4], ex0[4];
    bit eo, eo0;
    int cyc, bcnt;
    model(2, 2, 1, 1, mx, mzm, mzh, mk, ex, eo);
    model(2, 2, 0, 0, mx, mzm, mzh, mk, ex0, eo0);
    apply_main();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    bcnt = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && cyc < 40) begin
      start = (cyc == pulse_at) ? 1'b1 : 1'b0;
      if (cyc == change_at) begin
        rand_main();
        apply_main();
      end
      @(posedge clk); #1;
      cyc++;
      if (busy === 1'b1) bcnt++;
    end
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || cyc != 9) begin
      n_bad++; $display("FAIL %s latency: got %0d (done=%b) want 9", tag, cyc, done);
    end
    n_cmp++;
    if (bcnt != 9 || busy !== 1'b0) begin
      n_bad++; $display("FAIL %s busy: got %0d cycles (busy now %b) want 9", tag, bcnt, busy);
    end
    n_cmp++;
    if (done_r0 !== 1'b1) begin
      n_bad++; $display("FAIL %s done_r0: got %b want 1", tag, done_r0);
    end
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (longint'($signed(x_post[i*N +: N])) !== ex[i]) begin
        n_bad++; $display("FAIL %s x_post[%0d]: got %0d want %0d", tag, i, $signed(x_post[i*N +: N]), ex[i]);
      end
      n_cmp++;
      if (longint'($signed(x_post_r0[i*N +: N])) !== ex0[i]) begin
        n_bad++; $display("FAIL %s x_post_r0[%0d]: got %0d want %0d", tag, i, $signed(x_post_r0[i*N +: N]), ex0[i]);
      end
    end
    n_cmp++;
    if (ovf !== eo || ovf_r0 !== eo0) begin
      n_bad++; $display("FAIL %s ovf: got %b/%b want %b/%b", tag, ovf, ovf_r0, eo, eo0);
    end
  endtask

  task automatic run_big(input string tag);
    longint ex[4];
    bit eo;
    int cyc, bcnt;
    model(4, 3, 1, 1, bx, bzm, bzh, bk, ex, eo);
    apply_big();
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    cyc = 0;
    bcnt = (busy_b === 1'b1) ? 1 : 0;
    while (done_b !== 1'b1 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (busy_b === 1'b1) bcnt++;
    end
    n_cmp++;
    if (done_b !== 1'b1 || cyc != 20 || bcnt != 20) begin
      n_bad++; $display("FAIL %s latency: got %0d busy %0d want 20/20", tag, cyc, bcnt);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (longint'($signed(x_post_b[i*N +: N])) !== ex[i]) begin
        n_bad++; $display("FAIL %s x_post_b[%0d]: got %0d want %0d", tag, i, $signed(x_post_b[i*N +: N]), ex[i]);
      end
    end
    n_cmp++;
    if (ovf_b !== eo) begin
      n_bad++; $display("FAIL %s ovf_b: got %b want %b", tag, ovf_b, eo);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; start_b = 1'b0;
    xp = '0; zm = '0; zh = '0; kf = '0; xp_b = '0; zm_b = '0; zh_b = '0; kf_b = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (x_post !== '0 || x_post_r0 !== '0 || x_post_b !== '0) begin
      n_bad++; $display("FAIL reset x_post: got %h/%h/%h want 0", x_post, x_post_r0, x_post_b);
    end
    n_cmp++;
    if ({busy, busy_r0, busy_b} !== 3'b000) begin
      n_bad++; $display("FAIL reset busy: got %b%b%b want 000", busy, busy_r0, busy_b);
    end
    n_cmp++;
    if ({done, done_r0, done_b} !== 3'b000) begin
      n_bad++; $display("FAIL reset done: got %b%b%b want 000", done, done_r0, done_b);
    end
    n_cmp++;
    if ({ovf, ovf_r0, ovf_b} !== 3'b000) begin
      n_bad++; $display("FAIL reset ovf: got %b%b%b want 000", ovf, ovf_r0, ovf_b);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_directed();
    set_main(1024, -512, 2048, 1024, 1024, -512, 512, 0, 0, 512);
    run_main("diag", -1, -1);
    n_cmp++;
    if ($signed(x_post[0 +: N]) !== 20'sd1536 || $signed(x_post[N +: N]) !== 20'sd256 || ovf !== 1'b0) begin
      n_bad++; $display("FAIL diag literal: got %0d,%0d ovf %b want 1536,256 ovf 0", $signed(x_post[0 +: N]), $signed(x_post[N +: N]), ovf);
    end
    set_main(1024, -512, 2048, 1024, 1024, -512, 512, 256, 256, 512);
    run_main("cross", -1, -1);
    n_cmp++;
    if ($signed(x_post[0 +: N]) !== 20'sd1920 || $signed(x_post[N +: N]) !== 20'sd512) begin
      n_bad++; $display("FAIL cross literal: got %0d,%0d want 1920,512", $signed(x_post[0 +: N]), $signed(x_post[N +: N]));
    end
    set_main(524287, 0, 100000, 0, 0, 0, 1024, 0, 0, 0);
    run_main("sat_out", -1, -1);
    n_cmp++;
    if ($signed(x_post[0 +: N]) !== 20'sd524287 || ovf !== 1'b1) begin
      n_bad++; $display("FAIL sat_out literal: got %0d ovf %b want 524287 ovf 1", $signed(x_post[0 +: N]), ovf);
    end
    set_main(0, 0, 524287, 0, -524288, 0, 1024, 0, 0, 0);
    run_main("sat_innov", -1, -1);
    n_cmp++;
    if ($signed(x_post[0 +: N]) !== 20'sd524287 || ovf !== 1'b1 || $signed(x_post_r0[0 +: N]) !== -20'sd1) begin
      n_bad++; $display("FAIL sat_innov literal: got %0d ovf %b wrap %0d want 524287 ovf 1 wrap -1", $signed(x_post[0 +: N]), ovf, $signed(x_post_r0[0 +: N]));
    end
    set_main(3, 4, 10, 20, 10, 20, 100, 0, 0, 100);
    run_main("clean", -1, -1);
    n_cmp++;
    if (ovf !== 1'b0 || $signed(x_post[0 +: N]) !== 20'sd3) begin
      n_bad++; $display("FAIL clean literal: got %0d ovf %b want 3 ovf 0", $signed(x_post[0 +: N]), ovf);
    end
    set_main(0, 0, 512, 0, 0, 0, 1, 0, 0, 0);
    run_main("rnd_pos", -1, -1);
    n_cmp++;
    if ($signed(x_post[0 +: N]) !== 20'sd1 || $signed(x_post_r0[0 +: N]) !== 20'sd0) begin
      n_bad++; $display("FAIL rnd_pos literal: got %0d/%0d want 1/0", $signed(x_post[0 +: N]), $signed(x_post_r0[0 +: N]));
    end
    set_main(0, 0, -512, 0, 0, 0, 1, 0, 0, 0);
    run_main("rnd_neg", -1, -1);
    n_cmp++;
    if ($signed(x_post[0 +: N]) !== 20'sd0 || $signed(x_post_r0[0 +: N]) !== -20'sd1) begin
      n_bad++; $display("FAIL rnd_neg literal: got %0d/%0d want 0/-1", $signed(x_post[0 +: N]), $signed(x_post_r0[0 +: N]));
    end
  endtask

  task automatic test_handshake();
    int extra;
    rand_main();
    run_main("ignored_start", 3, -1);
    extra = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_bad++; $display("FAIL ignored_start extra activity: got %0d cycles want 0", extra);
    end
    rand_main();
    run_main("snapshot", -1, 2);
  endtask

  task automatic test_back_to_back();
    longint exa[4], exb[4];
    bit eo;
    int c1, c2;
    rand_main();
    model(2, 2, 1, 1, mx, mzm, mzh, mk, exa, eo);
    apply_main();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    c1 = 0;
    while (done !== 1'b1 && c1 < 40) begin
      @(posedge clk); #1; c1++;
    end
    // New inputs presented during the done cycle, start still held high.
    rand_main();
    model(2, 2, 1, 1, mx, mzm, mzh, mk, exb, eo);
    apply_main();
    n_cmp++;
    if (c1 != 9 || $signed(x_post[0 +: N]) !== exa[0] || $signed(x_post[N +: N]) !== exa[1]) begin
      n_bad++; $display("FAIL b2b first: got lat %0d x %0d,%0d want 9 x %0d,%0d", c1, $signed(x_post[0 +: N]), $signed(x_post[N +: N]), exa[0], exa[1]);
    end
    c2 = 0;
    do begin
      @(posedge clk); #1; c2++;
    end while (done !== 1'b1 && c2 < 40);
    start = 1'b0;
    n_cmp++;
    if (c2 != 10 || $signed(x_post[0 +: N]) !== exb[0] || $signed(x_post[N +: N]) !== exb[1] || ovf !== eo) begin
      n_bad++; $display("FAIL b2b second: got gap %0d x %0d,%0d ovf %b want 10 x %0d,%0d ovf %b", c2, $signed(x_post[0 +: N]), $signed(x_post[N +: N]), ovf, exb[0], exb[1], eo);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, seen;
    set_main(524287, 0, 100000, 0, 0, 0, 1024, 0, 0, 0);
    run_main("pre_abort", -1, -1);
    rand_main();
    apply_main();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (cyc < 3) begin
      @(posedge clk); #1; cyc++;
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (x_post !== '0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
      n_bad++; $display("FAIL abort state: got x %h busy %b done %b ovf %b want 0 0 0 0", x_post, busy, done, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (14) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++; $display("FAIL abort no_done: got %0d active cycles want 0", seen);
    end
    rand_main();
    run_main("after_abort", -1, -1);
  endtask

  task automatic test_random_main();
    for (int r = 0; r < 16; r++) begin
      rand_main();
      run_main($sformatf("rand%0d", r), -1, -1);
    end
  endtask

  task automatic test_big();
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 3; j++) bk[i][j] = (i == j) ? 1024 : 0;
      bx[i] = 10 * (i + 1);
    end
    for (int j = 0; j < 3; j++) begin
      bzm[j] = 5 + j;
      bzh[j] = 0;
    end
    run_big("big_diag");
    n_cmp++;
    if ($signed(x_post_b[0 +: N]) !== 20'sd15 || $signed(x_post_b[N +: N]) !== 20'sd26 ||
        $signed(x_post_b[2*N +: N]) !== 20'sd37 || $signed(x_post_b[3*N +: N]) !== 20'sd40) begin
      n_bad++; $display("FAIL big_diag literal: got %h want 15,26,37,40", x_post_b);
    end
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 4; i++) begin
        bx[i] = rs(16);
        for (int j = 0; j < 3; j++) bk[i][j] = rs(12);
      end
      for (int j = 0; j < 3; j++) begin
        bzm[j] = rs((r % 2 == 0) ? 12 : 20);
        bzh[j] = rs((r % 2 == 0) ? 12 : 20);
      end
      run_big($sformatf("big_rand%0d", r));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    test_random_main();
    test_big();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
